// File: rtl/atm_pkg.sv
// Shared definitions for the account transaction arbiter: op codes,
// response status codes, arbiter FSM state encoding and the reserved
// account index.
package atm_pkg;

  // Transaction op codes carried on req_op.
  typedef enum logic [1:0] {
    OP_BALANCE  = 2'b00,
    OP_DEPOSIT  = 2'b01,
    OP_WITHDRAW = 2'b10,
    OP_RSVD     = 2'b11
  } op_t;

  // Response status codes driven on rsp_status.
  typedef enum logic [1:0] {
    ST_OK           = 2'b00,
    ST_OVERFLOW     = 2'b01,
    ST_INSUFFICIENT = 2'b10,
    ST_BAD_REQ      = 2'b11
  } status_t;

  // Arbiter sequencing states: one pass per transaction.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_RESP = 2'b11
  } arb_state_t;

  // Account index that never maps to a real account.
  localparam int INVALID_ACCT = 15;

  // A request is malformed if it uses the reserved op or the reserved account.
  function automatic logic is_bad_req(input logic [1:0] op, input logic [31:0] acct);
    return (op == OP_RSVD) || (acct == 32'(INVALID_ACCT));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The pointer remembers the last granted index; the
// search for the next winner starts one past it and wraps. The pointer only
// moves when the owner of this arbiter signals that a grant was taken.
module rr_arbiter
  import atm_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  // Pick the first active request after the pointer, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        found      = 1'b1;
      end
    end
  end

  // Pointer starts at the last index so requester 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IDX_W'(N_REQ - 1);
    end else if (update && (|req)) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/account_txn_arbiter.sv
// Account transaction arbiter. Serialises balance/deposit/withdraw requests
// from several ATM front ends onto one balance RAM with a fixed
// read-check-write-respond sequence (one transaction every four cycles).
//
// Request handshake: a transfer happens in the cycle where
// req_valid[i] && req_ready[i]. req_ready is only raised in IDLE, for the
// round-robin winner among the requests valid in that same cycle, so a
// requester that drops req_valid before that cycle simply is not considered.
// The payload is captured on the transfer cycle; nothing is sampled later.
module account_txn_arbiter
  import atm_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ACCT_W = 4,
  parameter int BAL_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [2*N_REQ-1:0]      req_op,
  input  logic [ACCT_W*N_REQ-1:0] req_acct,
  input  logic [BAL_W*N_REQ-1:0]  req_amount,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [1:0]              rsp_status,
  output logic [BAL_W-1:0]        rsp_balance,
  output logic [ACCT_W-1:0]       mem_addr,
  output logic                    mem_rd_en,
  input  logic [BAL_W-1:0]        mem_rdata,
  output logic                    mem_wr_en,
  output logic [BAL_W-1:0]        mem_wdata
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state;

  // Latched transaction, valid from READ through RESP.
  logic [1:0]        op_q;
  logic [BAL_W-1:0]  amt_q;
  logic [IDX_W-1:0]  owner_q;
  logic              bad_q;

  // Arbiter interface.
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              take;

  // Winner's payload, selected from the packed request buses.
  logic [1:0]        sel_op;
  logic [ACCT_W-1:0] sel_acct;
  logic [BAL_W-1:0]  sel_amt;
  logic              sel_bad;

  // Result of the EXEC step.
  logic [BAL_W:0]    sum;
  status_t           res_status;
  logic [BAL_W-1:0]  res_bal;
  logic              res_wr;

  // A grant is taken only in IDLE, outside reset, with at least one request.
  assign take = (state == S_IDLE) && !rst && (|req_valid);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .update    (take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = take ? grant : '0;

  // Route the winning requester's fields out of the packed buses.
  always_comb begin
    sel_op   = req_op[int'(grant_idx)*2 +: 2];
    sel_acct = req_acct[int'(grant_idx)*ACCT_W +: ACCT_W];
    sel_amt  = req_amount[int'(grant_idx)*BAL_W +: BAL_W];
    sel_bad  = is_bad_req(sel_op, 32'(sel_acct));
  end

  // One extra bit of headroom exposes deposit overflow directly.
  assign sum = {1'b0, mem_rdata} + {1'b0, amt_q};

  // Decide status, returned balance and whether to write, from the read data.
  always_comb begin
    res_status = ST_OK;
    res_bal    = mem_rdata;
    res_wr     = 1'b0;
    if (bad_q) begin
      res_status = ST_BAD_REQ;
      res_bal    = '0;
    end else begin
      case (op_q)
        OP_DEPOSIT: begin
          if (sum[BAL_W]) begin
            res_status = ST_OVERFLOW;
          end else begin
            res_bal = sum[BAL_W-1:0];
            res_wr  = 1'b1;
          end
        end
        OP_WITHDRAW: begin
          if (amt_q > mem_rdata) begin
            res_status = ST_INSUFFICIENT;
          end else begin
            res_bal = mem_rdata - amt_q;
            res_wr  = 1'b1;
          end
        end
        default: begin
          res_status = ST_OK;
        end
      endcase
    end
  end

  // The write must land in the cycle the read data arrives, so it is driven
  // straight from EXEC; a write already strobed here is not revoked by reset.
  assign mem_wr_en = (state == S_EXEC) && res_wr;
  assign mem_wdata = mem_wr_en ? res_bal : '0;

  // Transaction sequencer: latch on grant, read, execute, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= '0;
      amt_q       <= '0;
      owner_q     <= '0;
      bad_q       <= 1'b0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      rsp_valid   <= '0;
      rsp_status  <= ST_OK;
      rsp_balance <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          rsp_valid <= '0;
          if (take) begin
            op_q      <= sel_op;
            amt_q     <= sel_amt;
            owner_q   <= grant_idx;
            bad_q     <= sel_bad;
            mem_addr  <= sel_acct;
            mem_rd_en <= !sel_bad;
            state     <= S_READ;
          end
        end
        S_READ: begin
          mem_rd_en <= 1'b0;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          rsp_status  <= res_status;
          rsp_balance <= res_bal;
          rsp_valid   <= N_REQ'(1) << owner_q;
          state       <= S_RESP;
        end
        S_RESP: begin
          rsp_valid <= '0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_account_txn_arbiter.sv
// Bench for account_txn_arbiter: a behavioural balance RAM, a cycle monitor
// that predicts every output from a transaction-level model of the accounts,
// directed scenarios and a randomized multi-requester phase.
module tb_account_txn_arbiter;

  localparam int N_REQ  = 2;
  localparam int ACCT_W = 4;
  localparam int BAL_W  = 4;
  localparam int BAL_MAX = (1 << BAL_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]        req_valid;
  logic [2*N_REQ-1:0]      req_op;
  logic [ACCT_W*N_REQ-1:0] req_acct;
  logic [BAL_W*N_REQ-1:0]  req_amount;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [1:0]              rsp_status;
  logic [BAL_W-1:0]        rsp_balance;
  logic [ACCT_W-1:0]       mem_addr;
  logic                    mem_rd_en;
  logic [BAL_W-1:0]        mem_rdata;
  logic                    mem_wr_en;
  logic [BAL_W-1:0]        mem_wdata;

  account_txn_arbiter #(
    .N_REQ  (N_REQ),
    .ACCT_W (ACCT_W),
    .BAL_W  (BAL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_acct    (req_acct),
    .req_amount  (req_amount),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .rsp_balance (rsp_balance),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rdata   (mem_rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata)
  );

  // ---------------- balance RAM ----------------
  logic [BAL_W-1:0] ram [16];
  logic             load_en;
  logic [3:0]       load_addr;
  logic [BAL_W-1:0] load_data;

  always @(posedge clk) begin
    if (load_en) ram[load_addr] <= load_data;
    else if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];   // expected grant sequence for the alternation test

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / monitor ----------------
  bit   mon_on = 1'b0;
  int   ref_bal [16];
  int   rr_ptr = N_REQ - 1;
  int   cyc = 0, g_cyc = 0, ph, w, j, cur;
  bit   active = 1'b0;
  int   t_owner, t_acct, t_st, t_bal;
  bit   t_rd, t_wr;
  bit   [N_REQ-1:0] hs = '0;
  logic rst_prev = 1'b0;
  logic [N_REQ-1:0] exp_ready;
  int   obs_st, obs_bal;
  int   grant_log_idx[$];
  int   grant_log_cyc[$];

  always @(negedge clk) begin
    if (load_en) ref_bal[load_addr] = int'(load_data);
    if (mon_on) begin
      cyc++;
      ph = active ? (cyc - g_cyc) : 99;

      // Outputs owed by the transaction in flight.
      check("rd_en", mem_rd_en, (ph == 1) && t_rd);
      if (ph == 1 && t_rd) check("rd_addr", mem_addr, t_acct);
      check("wr_en", mem_wr_en, (ph == 2) && t_wr);
      if (ph == 2 && t_wr) check("wr_data", mem_wdata, t_bal);
      check("rsp_valid", rsp_valid, (ph == 3) ? (1 << t_owner) : 0);
      if (ph == 3) begin
        check("rsp_status", rsp_status, t_st);
        check("rsp_balance", rsp_balance, t_bal);
        obs_st  = int'(rsp_status);
        obs_bal = int'(rsp_balance);
      end
      if (rst_prev) begin
        check("rst_status", rsp_status, 0);
        check("rst_balance", rsp_balance, 0);
      end

      // Grant prediction: free when idle, round-robin from last winner.
      exp_ready = '0;
      w = -1;
      if (!rst && ph >= 4) begin
        for (int k = 1; k <= N_REQ; k++) begin
          j = (rr_ptr + k) % N_REQ;
          if (w < 0 && req_valid[j]) w = j;
        end
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      check("req_ready", req_ready, exp_ready);
      hs = req_ready & req_valid;

      if (w >= 0) begin
        t_owner = w;
        t_acct  = int'(req_acct[w*ACCT_W +: ACCT_W]);
        cur     = ref_bal[t_acct];
        t_wr    = 1'b0;
        t_rd    = 1'b1;
        t_st    = 0;
        t_bal   = cur;
        if (req_op[w*2 +: 2] == 2'b11 || t_acct == 15) begin
          t_rd = 1'b0; t_st = 3; t_bal = 0;
        end else if (req_op[w*2 +: 2] == 2'b01) begin
          if (cur + int'(req_amount[w*BAL_W +: BAL_W]) > BAL_MAX) t_st = 1;
          else begin t_bal = cur + int'(req_amount[w*BAL_W +: BAL_W]); t_wr = 1'b1; end
        end else if (req_op[w*2 +: 2] == 2'b10) begin
          if (int'(req_amount[w*BAL_W +: BAL_W]) > cur) t_st = 2;
          else begin t_bal = cur - int'(req_amount[w*BAL_W +: BAL_W]); t_wr = 1'b1; end
        end
        if (t_wr) ref_bal[t_acct] = t_bal;
        active = 1'b1;
        g_cyc  = cyc;
        rr_ptr = w;
        grant_log_idx.push_back(w);
        grant_log_cyc.push_back(cyc);
      end

      if (rst) begin
        active = 1'b0;
        rr_ptr = N_REQ - 1;
        hs     = '0;
      end
      rst_prev = rst;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_bal(input int a, input int v);
    load_addr = 4'(a);
    load_data = BAL_W'(v);
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic put_req(input int i, input int op, input int acct, input int amt);
    req_op[i*2 +: 2]             = 2'(op);
    req_acct[i*ACCT_W +: ACCT_W] = ACCT_W'(acct);
    req_amount[i*BAL_W +: BAL_W] = BAL_W'(amt);
    req_valid[i]                 = 1'b1;
  endtask

  // Issue one request, wait for its transfer, then for its response cycle.
  task automatic do_txn(input int i, input int op, input int acct, input int amt);
    int n;
    put_req(i, op, acct, amt);
    n = 0;
    while (!hs[i] && n < 50) begin
      tick();
      n++;
    end
    if (!hs[i]) check("grant_timeout", 0, 1);
    req_valid[i] = 1'b0;
    repeat (4) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    req_valid = '0; req_op = '0; req_acct = '0; req_amount = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    rst = 1'b1;
    repeat (2) tick();
    mon_on = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);

    for (int a = 0; a < 16; a++) set_bal(a, $urandom_range(0, BAL_MAX));

    // Deposit 5 onto 7.
    set_bal(3, 7);
    do_txn(0, 1, 3, 5);
    check("dep_status", obs_st, 0);
    check("dep_balance", obs_bal, 12);
    check("dep_ram", ram[3], 12);

    // Withdraw too much, then exactly the balance.
    set_bal(2, 4);
    do_txn(1, 2, 2, 9);
    check("wd_insuf_status", obs_st, 2);
    check("wd_insuf_balance", obs_bal, 4);
    do_txn(1, 2, 2, 4);
    check("wd_all_status", obs_st, 0);
    check("wd_all_ram", ram[2], 0);

    // Overflowing deposit, then one that fills to the maximum.
    set_bal(5, 6);
    do_txn(0, 1, 5, 10);
    check("ovf_status", obs_st, 1);
    check("ovf_balance", obs_bal, 6);
    do_txn(0, 1, 5, 9);
    check("fill_balance", obs_bal, 15);
    check("fill_ram", ram[5], 15);

    // Zero-amount withdraw, plain balance query.
    do_txn(1, 2, 5, 0);
    check("wd0_status", obs_st, 0);
    do_txn(0, 0, 3, 7);
    check("bal_balance", obs_bal, 12);

    // Malformed requests.
    do_txn(0, 3, 1, 2);
    check("bad_op_status", obs_st, 3);
    check("bad_op_balance", obs_bal, 0);
    do_txn(1, 0, 15, 0);
    check("bad_acct_status", obs_st, 3);

    // Both requesters held valid: 0,1,0,1 four cycles apart.
    do_reset();
    grant_log_idx.delete();
    grant_log_cyc.delete();
    exp_q = {32'd0, 32'd1, 32'd0, 32'd1};
    put_req(0, 0, 0, 0);
    put_req(1, 0, 1, 0);
    n = 0;
    while (grant_log_idx.size() < 4 && n < 60) begin
      tick();
      n++;
    end
    req_valid = '0;
    repeat (5) tick();
    check("alt_count", (grant_log_idx.size() >= 4), 1);
    for (int k = 0; k < 4 && k < grant_log_idx.size(); k++) begin
      check("alt_order", grant_log_idx[k], exp_q[k]);
      if (k > 0) check("alt_spacing", grant_log_cyc[k] - grant_log_cyc[k-1], 4);
    end

    // Reset during EXEC of a deposit: write kept, no response.
    set_bal(4, 3);
    put_req(0, 1, 4, 2);
    n = 0;
    while (!hs[0] && n < 50) begin
      tick();
      n++;
    end
    if (!hs[0]) check("mid_rst_timeout", 0, 1);
    req_valid[0] = 1'b0;
    tick();             // now in EXEC
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ram", ram[4], 5);
    check("mid_rst_rsp", rsp_valid, 0);
    do_txn(0, 0, 4, 0);
    check("post_rst_balance", obs_bal, 5);
    do_txn(1, 2, 4, 1);
    check("post_rst_wd", obs_bal, 4);

    // Randomized traffic with withdrawals and immediate reissues.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) != 0)
            put_req(i, ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2),
                    ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3),
                    $urandom_range(0, BAL_MAX));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
